// File: rtl/ahb_dec_pkg.sv
// Shared encodings for the AHB-Lite decoder/mux and its optional watchdog.
// The watchdog is compiled in only when AHB_DEC_TIMEOUT_EN is defined.
package ahb_dec_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        WD_WAIT = 2'd0,
        WD_ERR1 = 2'd1,
        WD_ERR2 = 2'd2
    } wd_state_e;

    // Data-phase owner: 0 = no owner, 1..N = mapped slave i-1, N+1 = default slave.
    localparam int unsigned DSEL_NONE = 0;

    function automatic int unsigned dsel_width(input int unsigned num_slaves);
        return $clog2(num_slaves + 2);
    endfunction

    function automatic int unsigned dsel_slave(input int unsigned idx);
        return idx + 1;
    endfunction

    function automatic int unsigned dsel_def(input int unsigned num_slaves);
        return num_slaves + 1;
    endfunction

endpackage

// File: rtl/ahb_timeout_monitor.sv
// Data-phase stall watchdog: counts owner wait states and forces a two-cycle
// ERROR once the stall reaches TIMEOUT_CYCLES (instantiated under AHB_DEC_TIMEOUT_EN).
module ahb_timeout_monitor
    import ahb_dec_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic active,
    input  logic ready_in,
    input  logic HREADY,
    output logic err_phase1,
    output logic err_phase2,
    output logic dec_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    wd_state_e          r_state;
    wd_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= WD_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A stall edge that lands the count on TIMEOUT_CYCLES aborts; a ready edge never does.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            WD_WAIT: begin
                if (HREADY) begin
                    w_cnt_nxt = '0;
                end else if (active && !ready_in) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        w_state_nxt = WD_ERR1;
                    end
                end
            end
            WD_ERR1: begin
                w_state_nxt = WD_ERR2;
            end
            WD_ERR2: begin
                w_state_nxt = WD_WAIT;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = WD_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        err_phase1  = 1'b0;
        err_phase2  = 1'b0;
        dec_timeout = 1'b0;
        case (r_state)
            WD_ERR1: err_phase1 = 1'b1;
            WD_ERR2: begin
                err_phase2  = 1'b1;
                dec_timeout = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite single-master address decoder and slave response multiplexer.
// Define AHB_DEC_TIMEOUT_EN to add the data-phase stall watchdog.
module ahb_decoder_mux
    import ahb_dec_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REGION_BITS    = 4,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    output logic [NUM_SLAVES-1:0]            HSEL_S,
    output logic                             HSEL_D,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [2*NUM_SLAVES-1:0]          HRESP_S,
    input  logic [DATA_WIDTH-1:0]            HRDATA_D,
    input  logic                             HREADYOUT_D,
    input  logic [1:0]                       HRESP_D,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic [1:0]                       HRESP,
    output logic                             dec_timeout
);

    localparam int unsigned DSEL_W = dsel_width(NUM_SLAVES);
    localparam logic [DSEL_W-1:0] DSEL_NONE_C = DSEL_W'(DSEL_NONE);
    localparam logic [DSEL_W-1:0] DSEL_DEF_C  = DSEL_W'(dsel_def(NUM_SLAVES));

    if (NUM_SLAVES < 1 || NUM_SLAVES > (2**REGION_BITS) - 1) begin : g_bad_num_slaves
        $error("ahb_decoder_mux: NUM_SLAVES must be 1..2**REGION_BITS-1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ahb_decoder_mux: TIMEOUT_CYCLES must be at least 2");
    end
    if (ADDR_WIDTH <= REGION_BITS) begin : g_bad_addr
        $error("ahb_decoder_mux: ADDR_WIDTH must exceed REGION_BITS");
    end

    logic [REGION_BITS-1:0] w_region;
    logic                   w_in_map;
    logic                   w_trans_active;
    logic [DSEL_W-1:0]      w_dsel_addr;
    logic [DSEL_W-1:0]      r_dsel;
    logic                   w_own_ready;
    logic [1:0]             w_own_resp;
    logic [DATA_WIDTH-1:0]  w_own_rdata;
    logic                   w_err1;
    logic                   w_err2;
    logic                   w_unused_addr;

    assign w_region      = HADDR[ADDR_WIDTH-1 -: REGION_BITS];
    assign w_in_map      = (w_region < REGION_BITS'(NUM_SLAVES));
    assign w_unused_addr = ^HADDR[ADDR_WIDTH-REGION_BITS-1:0];

    // Address-phase decode: exactly one select every cycle, regardless of HTRANS.
    always_comb begin
        HSEL_S = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            HSEL_S[i] = (w_region == REGION_BITS'(i));
        end
        HSEL_D = !w_in_map;
    end

    assign w_trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign w_dsel_addr    = w_in_map ? (DSEL_W'(w_region) + DSEL_W'(1)) : DSEL_DEF_C;

    // Data-phase owner advances only when the current data phase completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel <= DSEL_NONE_C;
        end else if (HREADY) begin
            r_dsel <= w_trans_active ? w_dsel_addr : DSEL_NONE_C;
        end
    end

    // Owner response select; no owner reads as an idle OKAY with zero data.
    always_comb begin
        w_own_ready = 1'b1;
        w_own_resp  = HRESP_OKAY;
        w_own_rdata = '0;
        if (r_dsel == DSEL_DEF_C) begin
            w_own_ready = HREADYOUT_D;
            w_own_resp  = HRESP_D;
            w_own_rdata = HRDATA_D;
        end
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (r_dsel == DSEL_W'(dsel_slave(i))) begin
                w_own_ready = HREADYOUT_S[i];
                w_own_resp  = HRESP_S[2*i +: 2];
                w_own_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Watchdog abort phases override whatever the abandoned owner drives.
    always_comb begin
        HREADY = w_own_ready;
        HRESP  = w_own_resp;
        HRDATA = w_own_rdata;
        if (w_err1) begin
            HREADY = 1'b0;
            HRESP  = HRESP_ERROR;
            HRDATA = '0;
        end else if (w_err2) begin
            HREADY = 1'b1;
            HRESP  = HRESP_ERROR;
            HRDATA = '0;
        end
    end

`ifdef AHB_DEC_TIMEOUT_EN
    logic w_active;

    assign w_active = (r_dsel != DSEL_NONE_C);

    ahb_timeout_monitor #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_monitor (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .active      (w_active),
        .ready_in    (w_own_ready),
        .HREADY      (HREADY),
        .err_phase1  (w_err1),
        .err_phase2  (w_err2),
        .dec_timeout (dec_timeout)
    );
`else
    assign w_err1      = 1'b0;
    assign w_err2      = 1'b0;
    assign dec_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Self-checking bench for ahb_decoder_mux: a transaction-level bus model
// checked every cycle plus directed literal expectations.
module tb_ahb_decoder_mux;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 16;

    logic              HCLK;
    logic              HRESETn;
    logic [AW-1:0]     HADDR;
    logic [1:0]        HTRANS;
    logic [NS-1:0]     HSEL_S;
    logic              HSEL_D;
    logic [NS*DW-1:0]  HRDATA_S;
    logic [NS-1:0]     HREADYOUT_S;
    logic [2*NS-1:0]   HRESP_S;
    logic [DW-1:0]     HRDATA_D;
    logic              HREADYOUT_D;
    logic [1:0]        HRESP_D;
    logic [DW-1:0]     HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic              dec_timeout;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;
    int lowcnt;

    ahb_decoder_mux #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REGION_BITS(4),
        .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSEL_S(HSEL_S), .HSEL_D(HSEL_D), .HRDATA_S(HRDATA_S),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_D(HRDATA_D),
        .HREADYOUT_D(HREADYOUT_D), .HRESP_D(HRESP_D), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .dec_timeout(dec_timeout)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Bus model: who owns the data phase (-1 none, 0..NS-1 slave, NS default),
    // how long it has stalled, and which abort phase (0 none, 1 ERR1, 2 ERR2) is showing.
    int m_owner = -1;
    int m_phase = 0;
    int m_stall = 0;

    int          e_region;
    logic [4:0]  e_sel;
    logic        e_hready;
    logic [1:0]  e_hresp;
    logic [31:0] e_hrdata;
    logic        e_to;

    always_comb begin
        e_region = int'(HADDR[AW-1 -: 4]);
        e_sel    = (e_region < NS) ? (5'd1 << e_region) : 5'b10000;
        e_to     = (m_phase == 2);
        if (m_phase == 1) begin
            e_hready = 1'b0; e_hresp = 2'b01; e_hrdata = '0;
        end else if (m_phase == 2) begin
            e_hready = 1'b1; e_hresp = 2'b01; e_hrdata = '0;
        end else if (m_owner < 0) begin
            e_hready = 1'b1; e_hresp = 2'b00; e_hrdata = '0;
        end else if (m_owner == NS) begin
            e_hready = HREADYOUT_D; e_hresp = HRESP_D; e_hrdata = HRDATA_D;
        end else begin
            e_hready = HREADYOUT_S[m_owner];
            e_hresp  = HRESP_S[m_owner*2 +: 2];
            e_hrdata = HRDATA_S[m_owner*DW +: DW];
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_owner <= -1;
            m_phase <= 0;
            m_stall <= 0;
        end else begin
`ifdef AHB_DEC_TIMEOUT_EN
            case (m_phase)
                0: begin
                    if (e_hready) m_stall <= 0;
                    else begin
                        m_stall <= m_stall + 1;
                        if (m_stall + 1 == TO) m_phase <= 1;
                    end
                end
                1: m_phase <= 2;
                default: begin
                    m_phase <= 0;
                    m_stall <= 0;
                end
            endcase
`endif
            if (e_hready)
                m_owner <= HTRANS[1] ? ((e_region < NS) ? e_region : NS) : -1;
        end
    end

    always @(negedge HCLK) begin
        if (check_en) begin
            chk("cyc_hsel",    64'({HSEL_D, HSEL_S}), 64'(e_sel));
            chk("cyc_hready",  64'(HREADY),           64'(e_hready));
            chk("cyc_hresp",   64'(HRESP),            64'(e_hresp));
            chk("cyc_hrdata",  64'(HRDATA),           64'(e_hrdata));
            chk("cyc_timeout", 64'(dec_timeout),      64'(e_to));
        end
    end

    logic [31:0] addrs    [4] = '{32'h0000_0000, 32'h1000_0000, 32'h3000_0000, 32'h4000_0000};
    logic [4:0]  sel_exp  [4] = '{5'b00001, 5'b00010, 5'b01000, 5'b10000};
    logic [31:0] data_exp [4] = '{32'h5100_0000, 32'h5100_0001, 32'h5100_0003, 32'hDEAD_BEEF};

    initial begin
        HRESETn = 1'b1;
        HADDR = '0;
        HTRANS = 2'b00;
        for (int i = 0; i < NS; i++) HRDATA_S[i*DW +: DW] = 32'h5100_0000 | 32'(i);
        HREADYOUT_S = '1;
        HRESP_S = '0;
        HRDATA_D = 32'hDEAD_BEEF;
        HREADYOUT_D = 1'b1;
        HRESP_D = 2'b00;
        #2;
        HRESETn = 1'b0;
        check_en = 1'b1;
        repeat (2) tick();
        chk("rst_hready", 64'(HREADY), 64'd1);
        chk("rst_hresp",  64'(HRESP),  64'd0);
        chk("rst_hrdata", 64'(HRDATA), 64'd0);
        chk("rst_to",     64'(dec_timeout), 64'd0);
        HRESETn = 1'b1;
        tick();

        // Decode sweep, pipelined: each cycle's data phase belongs to the previous address.
        for (int i = 0; i < 4; i++) begin
            HADDR = addrs[i];
            HTRANS = 2'b10;
            #1;
            chk("sweep_sel", 64'({HSEL_D, HSEL_S}), 64'(sel_exp[i]));
            if (i > 0) chk("sweep_data", 64'(HRDATA), 64'(data_exp[i-1]));
            tick();
        end
        HTRANS = 2'b00;
        #1;
        chk("sweep_data_def", 64'(HRDATA), 64'(data_exp[3]));
        tick();

        // Default slave two-cycle ERROR.
        HADDR = 32'hF000_0000;
        HTRANS = 2'b10;
        #1;
        chk("def_sel", 64'(HSEL_D), 64'd1);
        tick();
        HTRANS = 2'b00;
        HADDR = '0;
        HREADYOUT_D = 1'b0;
        HRESP_D = 2'b01;
        #1;
        chk("def_err1_ready", 64'(HREADY), 64'd0);
        chk("def_err1_resp",  64'(HRESP),  64'd1);
        tick();
        HREADYOUT_D = 1'b1;
        #1;
        chk("def_err2_ready", 64'(HREADY), 64'd1);
        chk("def_err2_resp",  64'(HRESP),  64'd1);
        tick();
        HRESP_D = 2'b00;

        // IDLE then BUSY to slave 2: no data phase, its wait state is ignored.
        HREADYOUT_S[2] = 1'b0;
        HADDR = 32'h2000_0000;
        HTRANS = 2'b00;
        #1;
        chk("idle_sel", 64'({HSEL_D, HSEL_S}), 64'b00100);
        tick();
        HTRANS = 2'b01;
        #1;
        chk("idle_ready", 64'(HREADY), 64'd1);
        chk("idle_resp",  64'(HRESP),  64'd0);
        chk("idle_data",  64'(HRDATA), 64'd0);
        tick();
        HTRANS = 2'b00;
        #1;
        chk("busy_ready", 64'(HREADY), 64'd1);
        chk("busy_data",  64'(HRDATA), 64'd0);
        tick();
        HREADYOUT_S[2] = 1'b1;

        // Slave 0 stalls.
        HADDR = 32'h0000_0000;
        HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00;
        HREADYOUT_S[0] = 1'b0;
        lowcnt = 0;
`ifdef AHB_DEC_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            #1;
            if (HREADY === 1'b0 && HRESP === 2'b00) lowcnt++;
            tick();
        end
        chk("wd_low_cycles", 64'(lowcnt), 64'd16);
        #1;
        chk("wd_err1_ready", 64'(HREADY), 64'd0);
        chk("wd_err1_resp",  64'(HRESP),  64'd1);
        chk("wd_err1_data",  64'(HRDATA), 64'd0);
        chk("wd_err1_to",    64'(dec_timeout), 64'd0);
        tick();
        #1;
        chk("wd_err2_ready", 64'(HREADY), 64'd1);
        chk("wd_err2_resp",  64'(HRESP),  64'd1);
        chk("wd_err2_to",    64'(dec_timeout), 64'd1);
        tick();
        #1;
        chk("wd_after_to",   64'(dec_timeout), 64'd0);
        chk("wd_after_ready", 64'(HREADY), 64'd1);
        HREADYOUT_S[0] = 1'b1;
        tick();

        // Release on the 16th cycle: normal completion, no abort.
        HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00;
        HREADYOUT_S[0] = 1'b0;
        repeat (TO - 1) tick();
        HREADYOUT_S[0] = 1'b1;
        #1;
        chk("edge_ready", 64'(HREADY), 64'd1);
        chk("edge_resp",  64'(HRESP),  64'd0);
        chk("edge_data",  64'(HRDATA), 64'h5100_0000);
        tick();
        #1;
        chk("edge_no_to",    64'(dec_timeout), 64'd0);
        chk("edge_no_err",   64'(HRESP), 64'd0);
        tick();
        #1;
        chk("edge_no_to2",   64'(dec_timeout), 64'd0);
        chk("edge_ready2",   64'(HREADY), 64'd1);
        tick();
`else
        for (int c = 0; c < 100; c++) begin
            #1;
            if (HREADY === 1'b0) lowcnt++;
            tick();
        end
        chk("stall_low_cycles", 64'(lowcnt), 64'd100);
        chk("stall_ready", 64'(HREADY), 64'd0);
        chk("stall_to",    64'(dec_timeout), 64'd0);
        HREADYOUT_S[0] = 1'b1;
        #1;
        chk("stall_release", 64'(HREADY), 64'd1);
        tick();
`endif

        // Reset in the middle of a slave 1 stall.
        HADDR = 32'h1000_0000;
        HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00;
        HREADYOUT_S[1] = 1'b0;
        repeat (3) tick();
        HRESETn = 1'b0;
        #1;
        chk("mrst_ready", 64'(HREADY), 64'd1);
        chk("mrst_resp",  64'(HRESP),  64'd0);
        chk("mrst_data",  64'(HRDATA), 64'd0);
        chk("mrst_to",    64'(dec_timeout), 64'd0);
        tick();
        HREADYOUT_S[1] = 1'b1;
        HRESETn = 1'b1;
        HTRANS = 2'b10;
        #1;
        chk("post_rst_idle", 64'(HRDATA), 64'd0);
        tick();
        HTRANS = 2'b00;
        #1;
        chk("post_rst_data",  64'(HRDATA), 64'h5100_0001);
        chk("post_rst_ready", 64'(HREADY), 64'd1);
        tick();
        tick();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
